// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the shared-resource multicycle MIPS datapath.
// A Moore machine sequences one ALU and one unified memory port across the
// instruction phases. Outputs are decoded from the state. The exceptions are
// pc_write/ir_write, which follow mem_ready_i and zero_i, and the DECODE
// illegal/done pulse, which follows op_i.
module multicycle_ctrl (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] op_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       mem_to_reg_o,
    output logic       reg_dst_o,
    output logic       reg_write_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic [3:0] state_o,
    output logic       instr_done_o,
    output logic       illegal_o
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t r_state;
    state_t w_next_state;

    assign state_o = r_state;

    // State register; reset aborts any instruction in flight and restarts at FETCH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst_i) r_state <= S_FETCH;
        else       r_state <= w_next_state;
    end

    // Next-state logic: phase sequencing by opcode and memory handshake.
    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        w_next_state = r_state;
        unique case (r_state)
            S_FETCH:     if (mem_ready_i) w_next_state = S_DECODE;
            S_DECODE: begin
                case (op_i)
                    OP_LW, OP_SW:     w_next_state = S_MEM_ADDR;
                    OP_RTYPE:         w_next_state = S_R_EXEC;
                    OP_BEQ, OP_BNE:   w_next_state = S_BRANCH;
                    OP_J:             w_next_state = S_JUMP;
                    OP_ADDI, OP_SLTI: w_next_state = S_I_EXEC;
                    default:          w_next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  w_next_state = (op_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready_i) w_next_state = S_MEM_WB;
            S_MEM_WB:    w_next_state = S_FETCH;
            S_MEM_WRITE: if (mem_ready_i) w_next_state = S_FETCH;
            S_R_EXEC:    w_next_state = S_R_WB;
            S_R_WB:      w_next_state = S_FETCH;
            S_I_EXEC:    w_next_state = S_I_WB;
            S_I_WB:      w_next_state = S_FETCH;
            S_BRANCH:    w_next_state = S_FETCH;
            S_JUMP:      w_next_state = S_FETCH;
            default:     w_next_state = S_FETCH;
        endcase
    end

    // Output decode per state; strobes are gated off while reset is held.
    always_comb begin
        pc_write_o   = 1'b0;
        i_or_d_o     = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_dst_o    = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        pc_source_o  = 2'b00;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b_o = 2'b11;
                case (op_i)
                    OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
                    OP_ADDI, OP_SLTI, OP_J: illegal_o = 1'b0;
                    default:                illegal_o = 1'b1;
                endcase
                instr_done_o = illegal_o;
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            S_MEM_READ: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_o  = 1'b1;
                i_or_d_o     = 1'b1;
                instr_done_o = mem_ready_i;
            end
            S_R_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
            end
            S_R_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            S_I_EXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = 2'b11;
            end
            S_I_WB: begin
                reg_write_o  = 1'b1;
                instr_done_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o  = 1'b1;
                alu_op_o     = 2'b01;
                pc_source_o  = 2'b01;
                instr_done_o = 1'b1;
                if (op_i == OP_BEQ)      pc_write_o = zero_i;
                else if (op_i == OP_BNE) pc_write_o = ~zero_i;
            end
            S_JUMP: begin
                pc_source_o  = 2'b10;
                pc_write_o   = 1'b1;
                instr_done_o = 1'b1;
            end
            default: begin
                alu_src_b_o = 2'b01;
            end
        endcase
        if (rst_i) begin
            pc_write_o   = 1'b0;
            mem_read_o   = 1'b0;
            mem_write_o  = 1'b0;
            ir_write_o   = 1'b0;
            reg_write_o  = 1'b0;
            instr_done_o = 1'b0;
            illegal_o    = 1'b0;
        end
    end

endmodule
